// File: rtl/lsu_port_arb_pkg.sv
// Shared definitions for the LSU port arbiter.
// Holds the arbiter FSM state enum, the atomic-flag bit position inside the
// op type field, and the index/type typedefs used by both requesters.
package lsu_port_arb_pkg;

  // Bit of the 6-bit op type that marks an atomic (locking) operation.
  localparam int unsigned AMO_TYPE_BIT = 4;

  typedef logic [3:0] idx_t;
  typedef logic [5:0] type_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StLocked,
    StIssue1,
    StDone
  } arb_state_e;

  function automatic logic is_amo(input type_t op_type);
    return op_type[AMO_TYPE_BIT];
  endfunction

endpackage

// File: rtl/lsu_port_arb.sv
// Two-requester arbiter in front of a single LSU port.
//
// Requester 0 issues memory ops. An atomic op (type bit AMO_TYPE_BIT set)
// locks the port after it is accepted; only requester 1 presenting the
// write-back for the same index may then use the port. While locked,
// requester 0 is held off. Requester 1 is never granted outside the lock.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   i_drive0 / o_free0    requester 0 handshake (free is a 1-cycle pulse)
//   i_addr0, i_index0, i_type0, i_storedata0, i_areg0   requester 0 payload
//   i_drive1 / o_free1    requester 1 (atomic write-back) handshake
//   i_result1, i_index1   requester 1 payload
//   o_driveToLSU / i_freeFromLSU  LSU handshake
//   o_addr, o_index, o_type, o_data, o_areg, o_isWb  LSU payload
//   o_locked              port is held for an atomic write-back
//   o_lockTimeout         1-cycle pulse when the lock watchdog fires
//
// Build option
//   LSU_ARB_TIMEOUT_EN    enables the lock watchdog (TIMEOUT_CYC LOCKED
//                         cycles); without it o_lockTimeout is tied low and
//                         the lock waits indefinitely.
module lsu_port_arb
  import lsu_port_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_drive0,
  output logic              o_free0,
  input  logic [DATA_W-1:0] i_addr0,
  input  logic [3:0]        i_index0,
  input  logic [5:0]        i_type0,
  input  logic [DATA_W-1:0] i_storedata0,
  input  logic [4:0]        i_areg0,
  input  logic              i_drive1,
  output logic              o_free1,
  input  logic [DATA_W-1:0] i_result1,
  input  logic [3:0]        i_index1,
  output logic              o_driveToLSU,
  input  logic              i_freeFromLSU,
  output logic [DATA_W-1:0] o_addr,
  output logic [3:0]        o_index,
  output logic [5:0]        o_type,
  output logic [DATA_W-1:0] o_data,
  output logic [4:0]        o_areg,
  output logic              o_isWb,
  output logic              o_locked,
  output logic              o_lockTimeout
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  arb_state_e        r_state;
  logic              r_drive;
  logic              r_free0;
  logic              r_free1;
  logic              r_locked;
  logic [DATA_W-1:0] r_addr;
  idx_t              r_index;
  type_t             r_type;
  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_areg;
  logic              r_is_wb;
  logic              w_idx_match;

  assign w_idx_match = i_drive1 && (i_index1 == r_index);

`ifdef LSU_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  // Counter value seen during the last permitted LOCKED cycle.
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] r_tmo_cnt;
  logic            r_tmo;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= StIdle;
      r_drive  <= 1'b0;
      r_free0  <= 1'b0;
      r_free1  <= 1'b0;
      r_locked <= 1'b0;
      r_addr   <= '0;
      r_index  <= '0;
      r_type   <= '0;
      r_data   <= '0;
      r_areg   <= '0;
      r_is_wb  <= 1'b0;
`ifdef LSU_ARB_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
`endif
    end else begin
      // Free/timeout strobes are single-cycle pulses.
      r_free0 <= 1'b0;
      r_free1 <= 1'b0;
`ifdef LSU_ARB_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
      unique case (r_state)
        // Requester 1 is deliberately not looked at here: it only ever
        // completes an atomic that already holds the lock.
        StIdle: begin
          if (i_drive0) begin
            r_addr  <= i_addr0;
            r_index <= i_index0;
            r_type  <= i_type0;
            r_data  <= i_storedata0;
            r_areg  <= i_areg0;
            r_is_wb <= 1'b0;
            r_drive <= 1'b1;
            r_state <= StIssue0;
          end
        end
        StIssue0: begin
          if (i_freeFromLSU) begin
            r_drive <= 1'b0;
            r_free0 <= 1'b1;
            if (is_amo(r_type)) begin
              r_locked <= 1'b1;
              r_state  <= StLocked;
`ifdef LSU_ARB_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end else begin
              r_state <= StDone;
            end
          end
        end
        StLocked: begin
          // Address, type and areg of the locked op are reused as-is.
          if (w_idx_match) begin
            r_data  <= i_result1;
            r_is_wb <= 1'b1;
            r_drive <= 1'b1;
            r_state <= StIssue1;
          end
`ifdef LSU_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == TmoLast) begin
            r_tmo    <= 1'b1;
            r_locked <= 1'b0;
            r_state  <= StIdle;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CntW'(1);
          end
`endif
        end
        StIssue1: begin
          if (i_freeFromLSU) begin
            r_drive  <= 1'b0;
            r_free1  <= 1'b1;
            r_locked <= 1'b0;
            r_is_wb  <= 1'b0;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_driveToLSU = r_drive;
  assign o_free0      = r_free0;
  assign o_free1      = r_free1;
  assign o_locked     = r_locked;
  assign o_addr       = r_addr;
  assign o_index      = r_index;
  assign o_type       = r_type;
  assign o_data       = r_data;
  assign o_areg       = r_areg;
  assign o_isWb       = r_is_wb;

`ifdef LSU_ARB_TIMEOUT_EN
  assign o_lockTimeout = r_tmo;
`else
  assign o_lockTimeout = 1'b0;
`endif

endmodule
